mem_stage_ctrl: RTL

//  MEM stage of the 5-stage MIPS pipeline; consumes the EXE/MEM pipeline register outputs.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mem_wb_reg.sv | 41 ++++
 rtl/mem_stage_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Purpose: shared MIPS pipeline field indices, MEM-stage FSM encoding and MEM/WB payload type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // MEM control field bit positions: {Branch, MemRead, MemWrite}
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  // WB control field bit positions: {RegWrite, MemtoReg}
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // MEM-stage access FSM
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  // Non-load payload carried into the MEM/WB register
  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  wreg;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// Purpose: MEM/WB pipeline register with bubble insertion; WB control zeroed on any bubble.
// Latency: 1 cycle from D inputs to Q outputs.
// Backpressure: bubble=1 loads an invalid entry while data fields keep their previous values.
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bubble,
  input  logic        valid_d,
  input  mem_wb_t     ctl_d,
  input  logic        rd_load,
  input  logic [31:0] rdata_d,
  output logic        valid_q,
  output mem_wb_t     ctl_q,
  output logic [31:0] rdata_q
);

  // Pipeline register: bubbles clear valid/WB only, load data updates only on an acked read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (bubble) begin
        valid_q  <= 1'b0;
        ctl_q.wb <= 2'b00;
      end else begin
        valid_q    <= valid_d;
        ctl_q.wb   <= valid_d ? ctl_d.wb : 2'b00;
        ctl_q.alu  <= ctl_d.alu;
        ctl_q.wreg <= ctl_d.wreg;
      end
      if (rd_load) begin
        rdata_q <= rdata_d;
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: MIPS MEM stage - branch resolve, req/ack data-memory access with timeout, MEM/WB register.
// Latency: 1 cycle from ack (or from entry for non-memory ops) to MEM/WB outputs.
// Backpressure: stall holds upstream stages while an access waits for ack; timeout aborts and releases.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [31:0]       addPc,
  input  logic [31:0]       aluResult,
  input  logic              zero,
  input  logic [31:0]       readData2,
  input  logic [4:0]        writeReg,
  input  logic [1:0]        WB,
  input  logic [2:0]        MEM,
  output logic              stall,
  output logic              pcSrc,
  output logic [31:0]       branchTarget,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_err,
  output logic              memWbValid,
  output logic [31:0]       readDataOut,
  output logic [31:0]       aluResultOut,
  output logic [4:0]        writeRegOut,
  output logic [1:0]        WBOut
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             memop, misal, timeout;
  logic             req_int, stall_int, ack_eff, rd_load;
  mem_wb_t          ctl_d, ctl_q;

  assign memop   = in_valid & (MEM[MEMREAD] | MEM[MEMWRITE]);
  assign misal   = memop & (aluResult[1:0] != 2'b00);
  assign timeout = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // An ack only counts while a request is actually being driven; stray acks are dropped
  assign ack_eff = req_int & dmem_ack;
  // MemRead together with MemWrite is a write, so no load data is captured
  assign rd_load = ack_eff & MEM[MEMREAD] & ~MEM[MEMWRITE];

  // Request/stall are gated by reset so an abandoned access drops the instant reset asserts
  assign dmem_req     = reset_n & req_int;
  assign stall        = reset_n & stall_int;
  assign dmem_we      = MEM[MEMWRITE];
  assign dmem_addr    = aluResult[ADDR_W+1:2];
  assign dmem_wdata   = readData2;
  assign pcSrc        = in_valid & MEM[BRANCH] & zero;
  assign branchTarget = addPc;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, request and stall; timeout takes priority over a coincident ack
  always_comb begin
    state_d   = state_q;
    req_int   = 1'b0;
    stall_int = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop && !misal) begin
          req_int = 1'b1;
          if (!dmem_ack) begin
            stall_int = 1'b1;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timeout) begin
          state_d = S_IDLE;
        end else begin
          req_int = 1'b1;
          if (dmem_ack) state_d = S_IDLE;
          else          stall_int = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait-cycle counter: zero while idle so it starts at 0 on entry to WAIT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                cnt_q <= '0;
    else if (state_q == S_IDLE)  cnt_q <= '0;
    else if (!timeout)           cnt_q <= cnt_q + CNT_W'(1);
  end

  // Sticky error flag for misaligned or timed-out accesses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              mem_err <= 1'b0;
    else if (misal || timeout) mem_err <= 1'b1;
  end

  assign ctl_d.wb   = WB;
  assign ctl_d.alu  = aluResult;
  assign ctl_d.wreg = writeReg;

  mem_wb_reg u_mem_wb (
    .clock   (clock),
    .reset_n (reset_n),
    .bubble  (stall_int),
    .valid_d (in_valid & ~misal & ~timeout),
    .ctl_d   (ctl_d),
    .rd_load (rd_load),
    .rdata_d (dmem_rdata),
    .valid_q (memWbValid),
    .ctl_q   (ctl_q),
    .rdata_q (readDataOut)
  );

  assign aluResultOut = ctl_q.alu;
  assign writeRegOut  = ctl_q.wreg;
  assign WBOut        = ctl_q.wb;

endmodule
